// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared constants, flag indices and operand classes for fp_mul_pipe
// Ports: none (package). Default-format constants plus helpers that derive
// BIAS/EMAX for any exponent width.
package fp_mul_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  localparam int BIAS   = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int EMAX   = (1 << EXP_W_DEF) - 1;
  localparam int W      = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int PROD_W = 2 * MAN_W_DEF + 2;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int emax_of(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational operand unpack and classification
// Ports: op (packed {sign, exp, frac}) in; cls, sign, exp (biased), sig
// (significand with hidden bit) out. Subnormals are reported as zero.
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] op,
  output fp_cls_e              cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig
);

  logic [MAN_W-1:0] frac;

  assign sign = op[EXP_W+MAN_W];
  assign exp  = op[EXP_W+MAN_W-1:MAN_W];
  assign frac = op[MAN_W-1:0];

  always_comb begin
    cls = CLS_NORM;
    sig = {1'b1, frac};
    if (exp == '0) begin
      // Denormals-are-zero: the fraction is discarded, sign is kept.
      cls = CLS_ZERO;
      sig = '0;
    end else if (&exp) begin
      cls = (frac == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 4-stage IEEE-754 multiplier with global-stall valid/ready
// Ports: clk, rst_n (async low); in_valid/in_ready/in_a/in_b/in_rm/in_tag
// operand beat; out_valid/out_ready/out_res/out_flags {NV,OF,UF,NX}/out_tag.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_rm,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_res,
  output logic [3:0]           out_flags,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS_X = XW'(bias_of(EXP_W));
  localparam logic [XW-1:0] EMAX_X = XW'(emax_of(EXP_W));
  localparam logic [EXP_W+MAN_W-1:0] INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [EXP_W+MAN_W-1:0] MAXF_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  localparam logic [EXP_W+MAN_W:0]   QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Every stage moves together; the output register is the only place a
  // result can wait, so a full output blocks the whole pipe.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  fp_cls_e          cls_a, cls_b;
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   siga, sigb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op(in_a), .cls(cls_a), .sign(sa), .exp(ea), .sig(siga)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op(in_b), .cls(cls_b), .sign(sb), .exp(eb), .sig(sigb)
  );

  logic c_nan, c_inf, c_zero;
  assign c_nan  = (cls_a == CLS_NAN) | (cls_b == CLS_NAN) |
                  ((cls_a == CLS_INF) & (cls_b == CLS_ZERO)) |
                  ((cls_a == CLS_ZERO) & (cls_b == CLS_INF));
  assign c_inf  = (cls_a == CLS_INF) | (cls_b == CLS_INF);
  assign c_zero = (cls_a == CLS_ZERO) | (cls_b == CLS_ZERO);

  // Stage registers. Special-case flags ride along so stage 4 can override.
  logic             s1_valid, s1_rm, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [TAG_W-1:0] s1_tag;
  logic [XW-1:0]    s1_exp;
  logic [PW-1:0]    s1_prod;

  logic             s2_valid, s2_rm, s2_sign, s2_nan, s2_inf, s2_zero, s2_g, s2_s;
  logic [TAG_W-1:0] s2_tag;
  logic [XW-1:0]    s2_exp;
  logic [MAN_W:0]   s2_mant;

  logic             s3_valid, s3_rm, s3_sign, s3_nan, s3_inf, s3_zero, s3_nx;
  logic [TAG_W-1:0] s3_tag;
  logic [XW-1:0]    s3_exp;
  logic [MAN_W-1:0] s3_mant;

  // Normalise: product of two [1,2) significands lies in [1,4).
  logic [PW-1:0]  n_prod;
  logic [MAN_W:0] n_mant;
  logic           n_g, n_s;
  logic [XW-1:0]  n_exp;
  assign n_prod = s1_prod[PW-1] ? s1_prod : {s1_prod[PW-2:0], 1'b0};
  assign n_mant = n_prod[PW-1 -: MAN_W+1];
  assign n_g    = n_prod[PW-MAN_W-2];
  assign n_s    = |n_prod[PW-MAN_W-3:0];
  assign n_exp  = s1_exp + XW'(s1_prod[PW-1]);

  // Round: a carry out of the significand only happens from all-ones, so
  // the shifted-down value is exactly the hidden bit.
  logic           r_inc;
  logic [MAN_W+1:0] r_sum;
  logic [MAN_W:0] r_mant;
  logic [XW-1:0]  r_exp;
  assign r_inc  = (s2_rm == RM_RNE) & s2_g & (s2_s | s2_mant[0]);
  assign r_sum  = {1'b0, s2_mant} + (MAN_W+2)'(r_inc);
  assign r_mant = r_sum[MAN_W+1] ? r_sum[MAN_W+1:1] : r_sum[MAN_W:0];
  assign r_exp  = s2_exp + XW'(r_sum[MAN_W+1]);

  // Pack and resolve specials, highest priority first.
  logic [EXP_W+MAN_W:0] p_res;
  logic [3:0]           p_flags;
  always_comb begin
    p_res           = {s3_sign, s3_exp[EXP_W-1:0], s3_mant};
    p_flags         = '0;
    p_flags[FLG_NX] = s3_nx;
    if (s3_nan) begin
      p_res           = QNAN;
      p_flags         = '0;
      p_flags[FLG_NV] = 1'b1;
    end else if (s3_inf) begin
      p_res   = {s3_sign, INF_MAG};
      p_flags = '0;
    end else if (s3_zero) begin
      p_res   = {s3_sign, {(EXP_W+MAN_W){1'b0}}};
      p_flags = '0;
    end else if ($signed(s3_exp) >= $signed(EMAX_X)) begin
      p_res           = (s3_rm == RM_RTZ) ? {s3_sign, MAXF_MAG} : {s3_sign, INF_MAG};
      p_flags         = '0;
      p_flags[FLG_OF] = 1'b1;
      p_flags[FLG_NX] = 1'b1;
    end else if (s3_exp[XW-1] || (s3_exp == '0)) begin
      p_res           = {s3_sign, {(EXP_W+MAN_W){1'b0}}};
      p_flags         = '0;
      p_flags[FLG_UF] = 1'b1;
      p_flags[FLG_NX] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_rm <= 1'b0; s1_sign <= 1'b0; s1_nan <= 1'b0;
      s1_inf <= 1'b0; s1_zero <= 1'b0; s1_tag <= '0; s1_exp <= '0; s1_prod <= '0;
      s2_valid <= 1'b0; s2_rm <= 1'b0; s2_sign <= 1'b0; s2_nan <= 1'b0;
      s2_inf <= 1'b0; s2_zero <= 1'b0; s2_g <= 1'b0; s2_s <= 1'b0;
      s2_tag <= '0; s2_exp <= '0; s2_mant <= '0;
      s3_valid <= 1'b0; s3_rm <= 1'b0; s3_sign <= 1'b0; s3_nan <= 1'b0;
      s3_inf <= 1'b0; s3_zero <= 1'b0; s3_nx <= 1'b0;
      s3_tag <= '0; s3_exp <= '0; s3_mant <= '0;
      out_valid <= 1'b0; out_res <= '0; out_flags <= '0; out_tag <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_rm    <= in_rm;
      s1_tag   <= in_tag;
      s1_sign  <= sa ^ sb;
      s1_nan   <= c_nan;
      s1_inf   <= c_inf;
      s1_zero  <= c_zero;
      s1_exp   <= {2'b00, ea} + {2'b00, eb} - BIAS_X;
      s1_prod  <= PW'(siga) * PW'(sigb);

      s2_valid <= s1_valid;
      s2_rm    <= s1_rm;
      s2_tag   <= s1_tag;
      s2_sign  <= s1_sign;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_zero  <= s1_zero;
      s2_exp   <= n_exp;
      s2_mant  <= n_mant;
      s2_g     <= n_g;
      s2_s     <= n_s;

      s3_valid <= s2_valid;
      s3_rm    <= s2_rm;
      s3_tag   <= s2_tag;
      s3_sign  <= s2_sign;
      s3_nan   <= s2_nan;
      s3_inf   <= s2_inf;
      s3_zero  <= s2_zero;
      s3_exp   <= r_exp;
      s3_mant  <= r_mant[MAN_W-1:0];
      s3_nx    <= s2_g | s2_s;

      out_valid <= s3_valid;
      out_res   <= p_res;
      out_flags <= p_flags;
      out_tag   <= s3_tag;
    end
  end

endmodule
